// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
//   Shares one single-port, synchronous-read framebuffer RAM between the PPU
//   pixel writer and the HDMI scanout line fetcher. Two banks: the PPU fills
//   the back bank while scanout reads the front bank. Banks swap at scanout
//   vsync once the PPU has reported a finished frame. Scanout wins
//   arbitration, but a waiting write is let through after MAX_READ_BURST
//   consecutive reads.
//
// Handshake (both request ports): a transfer happens on a cycle where
//   valid && ready. ready is combinational from valid and arbiter state.
//   While valid && !ready the requester holds addr/data stable. ready never
//   asserts without valid.
//
// Ports:
//   clk_pixel, reset        pixel clock, async active-high reset
//   wr_valid/ready/addr/data PPU write into the back bank
//   frame_done               one-cycle pulse, PPU finished a frame
//   rd_valid/ready/addr      scanout read from the front bank
//   rd_data_valid, rd_data   read return, one cycle after the read grant
//   scan_vsync               one-cycle pulse at start of scanout vblank
//   ram_addr/we/wdata/rdata  RAM port, {bank, pixel}; rdata latency 1
//   front_bank               bank currently scanned out
//   swap_pending             finished frame waiting for vsync
module framebuffer_arbiter #(
  parameter int FB_DEPTH       = 23040,
  parameter int ADDR_WIDTH     = 15,
  parameter int PIXEL_WIDTH    = 2,
  parameter int MAX_READ_BURST = 4
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic                   frame_done,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_data_valid,
  output logic [PIXEL_WIDTH-1:0] rd_data,
  input  logic                   scan_vsync,
  output logic [ADDR_WIDTH:0]    ram_addr,
  output logic                   ram_we,
  output logic [PIXEL_WIDTH-1:0] ram_wdata,
  input  logic [PIXEL_WIDTH-1:0] ram_rdata,
  output logic                   front_bank,
  output logic                   swap_pending
);

  localparam int                      STARVE_WIDTH = $clog2(MAX_READ_BURST + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX   = STARVE_WIDTH'(MAX_READ_BURST);
  localparam logic [ADDR_WIDTH:0]     DEPTH_LIMIT  = (ADDR_WIDTH + 1)'(FB_DEPTH);

  logic [STARVE_WIDTH-1:0] starve_q;
  logic [STARVE_WIDTH-1:0] starve_d;
  logic                    wr_eligible;
  logic                    rd_grant;
  logic                    wr_grant;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    rd_oor_q;
  logic [PIXEL_WIDTH-1:0]  rd_data_q;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIMIT;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIMIT;

  // Arbitration, starvation accounting and RAM drive.
  always_comb begin
    // A pending swap freezes the back bank so the finished frame survives
    // until scanout picks it up.
    wr_eligible = wr_valid && !swap_pending;
    rd_grant    = 1'b0;
    wr_grant    = 1'b0;
    if (!reset) begin
      if (rd_valid && !(wr_eligible && (starve_q == STARVE_MAX))) begin
        rd_grant = 1'b1;
      end else if (wr_eligible) begin
        wr_grant = 1'b1;
      end
    end

    // Counts reads granted over a waiting write; any cycle without a
    // waiting write, or a write grant, restarts the count.
    starve_d = starve_q;
    if (wr_grant || !wr_eligible) begin
      starve_d = '0;
    end else if (rd_grant && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end

    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (rd_grant) begin
      ram_addr = {front_bank, rd_addr};
    end else if (wr_grant) begin
      ram_addr  = {~front_bank, wr_addr};
      ram_wdata = wr_data;
      // Out-of-range writes still handshake; the data is simply dropped.
      ram_we    = wr_in_range;
    end
  end

  assign wr_ready = wr_grant;
  assign rd_ready = rd_grant;

  // ram_rdata lines up with rd_data_valid; outside that cycle the last
  // returned pixel is held.
  always_comb begin
    rd_data = rd_data_q;
    if (rd_data_valid) begin
      rd_data = rd_oor_q ? '0 : ram_rdata;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      starve_q      <= '0;
      rd_data_valid <= 1'b0;
      rd_oor_q      <= 1'b0;
      rd_data_q     <= '0;
      front_bank    <= 1'b0;
      swap_pending  <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      rd_data_valid <= rd_grant;
      if (rd_grant) begin
        rd_oor_q <= !rd_in_range;
      end
      if (rd_data_valid) begin
        rd_data_q <= rd_data;
      end
      // A frame finishing on the vsync edge itself swaps straight away.
      if (scan_vsync && (swap_pending || frame_done)) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
      end else if (frame_done && !swap_pending) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule
